// File: rtl/gate_bist_controller.sv
// gate_bist_controller
// Built-in self-test sequencer for a two-input gate block (and/or/not/xor/xnor).
// Each run sweeps {a,b} = 00,01,10,11 once per pass. Every vector is held for a
// programmable settle time before the five outputs are compared against
// golden values derived from the registered stimulus. The first failing check
// is captured for debug, and failing checks are counted in a saturating counter.
module gate_bist_controller #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             not_in,
  input  logic             xor_in,
  input  logic             xnor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [4:0]       first_fail_mask
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [7:0] LP_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LP_PASS_LAST   = 8'(PASSES - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [1:0]       r_vec;
  logic [7:0]       r_settle;
  logic [7:0]       r_pass_cnt;
  logic             r_gate_a;
  logic             r_gate_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic             r_fail_valid;
  logic [1:0]       r_ff_vec;
  logic [4:0]       r_ff_mask;

  logic [4:0]       w_golden;
  logic [4:0]       w_observed;
  logic [4:0]       w_mask;
  logic             w_start_ok;
  logic             w_last_vec;
  logic             w_last_pass;

  // Saturating increment so a long multi-pass run never wraps the error count.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign w_start_ok  = start && !abort;
  assign w_last_vec  = (r_vec == 2'd3);
  assign w_last_pass = (r_pass_cnt == LP_PASS_LAST);

  // Golden values come from the registered stimulus, not from r_vec, so the
  // comparison always matches what the gate block actually sees.
  assign w_golden   = {~(r_gate_a ^ r_gate_b), r_gate_a ^ r_gate_b, ~r_gate_a,
                       r_gate_a | r_gate_b, r_gate_a & r_gate_b};
  assign w_observed = {xnor_in, xor_in, not_in, or_in, and_in};
  assign w_mask     = w_observed ^ w_golden;

  // Next-state decode; abort from any non-idle state returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_state_nxt = S_APPLY;
      S_APPLY:  w_state_nxt = abort ? S_IDLE : S_SETTLE;
      S_SETTLE: begin
        if (abort)                          w_state_nxt = S_IDLE;
        else if (r_settle == LP_SETTLE_LAST) w_state_nxt = S_CHECK;
        else                                w_state_nxt = S_SETTLE;
      end
      S_CHECK: begin
        if (abort)                       w_state_nxt = S_IDLE;
        else if (w_last_vec && w_last_pass) w_state_nxt = S_DONE;
        else                             w_state_nxt = S_APPLY;
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it tracks
  // state != IDLE cycle for cycle and drops together with an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Vector, settle and pass counters that walk the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec      <= 2'd0;
      r_settle   <= 8'd0;
      r_pass_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_vec      <= 2'd0;
          r_pass_cnt <= 8'd0;
        end
        S_APPLY:  r_settle <= 8'd0;
        S_SETTLE: r_settle <= r_settle + 8'd1;
        S_CHECK: begin
          if (!abort) begin
            if (!w_last_vec) begin
              r_vec <= r_vec + 2'd1;
            end else if (!w_last_pass) begin
              r_pass_cnt <= r_pass_cnt + 8'd1;
              r_vec      <= 2'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Gate stimulus: loaded on leaving APPLY, parked at 0 whenever heading to IDLE.
  always_ff @(posedge clk) begin
    if (rst || (w_state_nxt == S_IDLE)) begin
      r_gate_a <= 1'b0;
      r_gate_b <= 1'b0;
    end else if (r_state == S_APPLY) begin
      r_gate_a <= r_vec[1];
      r_gate_b <= r_vec[0];
    end
  end

  // Result bookkeeping: cleared on an accepted start, updated in CHECK,
  // reported one cycle after DONE. Results survive an abort for debug.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_ff_vec     <= 2'd0;
      r_ff_mask    <= 5'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_ff_vec     <= 2'd0;
            r_ff_mask    <= 5'd0;
          end
        end
        S_CHECK: begin
          if (!abort && (w_mask != 5'd0)) begin
            r_err <= sat_inc(r_err);
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_ff_vec     <= r_vec;
              r_ff_mask    <= w_mask;
            end
          end
        end
        S_DONE: begin
          if (!abort) begin
            r_done <= 1'b1;
            r_pass <= (r_err == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign gate_a          = r_gate_a;
  assign gate_b          = r_gate_b;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign fail_valid      = r_fail_valid;
  assign first_fail_vec  = r_ff_vec;
  assign first_fail_mask = r_ff_mask;

endmodule

// File: tb/tb_gate_bist_controller.sv
// tb_gate_bist_controller
// Drives three controller instances (defaults, long multi-pass with a 3-bit
// error counter, long settle time), each wired to a behavioural gate block
// with injectable faults, and compares results against a run-level model.
module tb_gate_bist_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] gate_fn(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~a, a | b, a & b};
  endfunction

  // ---------------- main instance (defaults) ----------------
  logic       m_start, m_abort, m_ga, m_gb, m_busy, m_done, m_pass, m_fv;
  logic [7:0] m_err;
  logic [1:0] m_ffv;
  logic [4:0] m_ffm;
  logic [4:0] m_fault [0:3];
  logic       m_xor_stuck;
  logic [4:0] m_obs;

  always_comb begin
    m_obs = gate_fn(m_ga, m_gb) ^ m_fault[{m_ga, m_gb}];
    if (m_xor_stuck) m_obs[3] = 1'b0;
  end

  gate_bist_controller u_main (
    .clk(clk), .rst(rst), .start(m_start), .abort(m_abort),
    .gate_a(m_ga), .gate_b(m_gb),
    .and_in(m_obs[0]), .or_in(m_obs[1]), .not_in(m_obs[2]), .xor_in(m_obs[3]), .xnor_in(m_obs[4]),
    .busy(m_busy), .done(m_done), .pass(m_pass), .err_count(m_err),
    .fail_valid(m_fv), .first_fail_vec(m_ffv), .first_fail_mask(m_ffm)
  );

  // ---------------- saturation instance ----------------
  logic       s_start, s_ga, s_gb, s_busy, s_done, s_pass, s_fv;
  logic [2:0] s_err;
  logic [1:0] s_ffv;
  logic [4:0] s_ffm;
  logic [4:0] s_obs;

  assign s_obs = gate_fn(s_ga, s_gb) ^ 5'b00001;

  gate_bist_controller #(.SETTLE_CYCLES(2), .PASSES(100), .ERR_W(3)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .abort(1'b0),
    .gate_a(s_ga), .gate_b(s_gb),
    .and_in(s_obs[0]), .or_in(s_obs[1]), .not_in(s_obs[2]), .xor_in(s_obs[3]), .xnor_in(s_obs[4]),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
    .fail_valid(s_fv), .first_fail_vec(s_ffv), .first_fail_mask(s_ffm)
  );

  // ---------------- long-settle instance ----------------
  logic       w_start, w_ga, w_gb, w_busy, w_done, w_pass, w_fv;
  logic [7:0] w_err;
  logic [1:0] w_ffv;
  logic [4:0] w_ffm;
  logic [4:0] w_obs;

  assign w_obs = gate_fn(w_ga, w_gb);

  gate_bist_controller #(.SETTLE_CYCLES(5), .PASSES(1), .ERR_W(8)) u_slow (
    .clk(clk), .rst(rst), .start(w_start), .abort(1'b0),
    .gate_a(w_ga), .gate_b(w_gb),
    .and_in(w_obs[0]), .or_in(w_obs[1]), .not_in(w_obs[2]), .xor_in(w_obs[3]), .xnor_in(w_obs[4]),
    .busy(w_busy), .done(w_done), .pass(w_pass), .err_count(w_err),
    .fail_valid(w_fv), .first_fail_vec(w_ffv), .first_fail_mask(w_ffm)
  );

  // Per-sample trace of the main instance; sample n is the cycle after edge E0+n.
  logic [1:0] tr_gate [0:63];
  logic       tr_busy [0:63];
  logic       tr_done [0:63];
  logic [7:0] tr_err  [0:63];
  logic       tr_fv   [0:63];
  logic       tr_pass [0:63];
  logic [6:0] tr_ff   [0:63];
  int         r_lat, r_busy_cnt, r_dones;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start the main instance and trace 30 samples; optional abort / reset /
  // second start at a chosen sample index (-1 = never).
  task automatic main_run(input int abort_at, input int rst_at, input int restart_at);
    r_lat = -1; r_busy_cnt = 0; r_dones = 0;
    @(negedge clk); m_start = 1'b1;
    @(negedge clk); m_start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tr_gate[n] = {m_ga, m_gb};
      tr_busy[n] = m_busy;
      tr_done[n] = m_done;
      tr_err[n]  = m_err;
      tr_fv[n]   = m_fv;
      tr_pass[n] = m_pass;
      tr_ff[n]   = {m_ffv, m_ffm};
      if (m_busy) r_busy_cnt++;
      if (m_done) begin
        r_dones++;
        if (r_lat < 0) r_lat = n;
      end
      m_abort = (n == abort_at);
      rst     = (n == rst_at);
      m_start = (n == restart_at);
      @(negedge clk);
    end
    m_abort = 1'b0; rst = 1'b0; m_start = 1'b0;
  endtask

  task automatic set_faults(input logic [4:0] f0, input logic [4:0] f1,
                            input logic [4:0] f2, input logic [4:0] f3);
    m_fault[0] = f0; m_fault[1] = f1; m_fault[2] = f2; m_fault[3] = f3;
  endtask

  initial begin
    logic [4:0] f [0:3];
    int exp_err, exp_vec, exp_mask, bad, n;
    logic exp_fv;

    rst = 1'b1; m_start = 1'b0; m_abort = 1'b0; m_xor_stuck = 1'b0;
    s_start = 1'b0; w_start = 1'b0;
    set_faults(5'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_main_outputs", {m_busy, m_done, m_pass, m_fv, m_ffv, m_ffm, m_err, m_ga, m_gb}, 0);
    chk("rst_sat_outputs",  {s_busy, s_done, s_pass, s_fv, s_ffv, s_ffm, s_err, s_ga, s_gb}, 0);
    chk("rst_slow_outputs", {w_busy, w_done, w_pass, w_fv, w_ffv, w_ffm, w_err, w_ga, w_gb}, 0);

    // Healthy run with defaults
    main_run(-1, -1, -1);
    chk("healthy_latency", r_lat, 17);
    chk("healthy_dones", r_dones, 1);
    chk("healthy_busy_cycles", r_busy_cnt, 17);
    chk("healthy_busy_in_done_state", tr_busy[16], 1);
    chk("healthy_busy_after", tr_busy[17], 0);
    chk("healthy_pass", m_pass, 1);
    chk("healthy_err", m_err, 0);
    chk("healthy_fail_valid", m_fv, 0);
    chk("healthy_gate_apply", tr_gate[0], 0);
    for (int k = 0; k < 4; k++) begin
      bad = 0;
      for (int j = 1 + 4 * k; j <= 4 + 4 * k; j++) if (tr_gate[j] != 2'(k)) bad++;
      chk($sformatf("healthy_vec%0d_hold_bad", k), bad, 0);
    end
    chk("healthy_gate_parked", tr_gate[17], 0);

    // Stuck-at-0 on xor output
    m_xor_stuck = 1'b1;
    main_run(-1, -1, -1);
    m_xor_stuck = 1'b0;
    chk("stuck_err", m_err, 2);
    chk("stuck_fail_valid", m_fv, 1);
    chk("stuck_first_vec", m_ffv, 2'b01);
    chk("stuck_first_mask", m_ffm, 5'b01000);
    chk("stuck_pass", m_pass, 0);
    chk("stuck_latency", r_lat, 17);

    // Randomised fault tables against the run-level model
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++)
        f[k] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      set_faults(f[0], f[1], f[2], f[3]);
      exp_err = 0; exp_fv = 1'b0; exp_vec = 0; exp_mask = 0;
      for (int k = 0; k < 4; k++) begin
        if (f[k] != 5'd0) begin
          if (!exp_fv) begin exp_fv = 1'b1; exp_vec = k; exp_mask = f[k]; end
          exp_err++;
        end
      end
      main_run(-1, -1, -1);
      chk($sformatf("rand%0d_err", r), m_err, exp_err);
      chk($sformatf("rand%0d_fv", r), m_fv, exp_fv);
      chk($sformatf("rand%0d_first", r), {m_ffv, m_ffm}, {exp_vec[1:0], exp_mask[4:0]});
      chk($sformatf("rand%0d_pass", r), m_pass, (exp_err == 0));
      chk($sformatf("rand%0d_latency", r), r_lat, 17);
    end

    // Abort in the second SETTLE cycle of vector 10, with a fault on vector 01
    set_faults(5'd0, 5'b00100, 5'd0, 5'd0);
    main_run(10, -1, -1);
    chk("abort_vec_at_abort", tr_gate[10], 2'b10);
    chk("abort_busy_next", tr_busy[11], 0);
    chk("abort_gate_next", tr_gate[11], 0);
    chk("abort_dones", r_dones, 0);
    chk("abort_err_kept", tr_err[11], 1);
    chk("abort_fv_kept", {tr_fv[11], tr_ff[11]}, {1'b1, 2'b01, 5'b00100});
    chk("abort_pass", tr_pass[11], 0);
    set_faults(5'd0, 5'd0, 5'd0, 5'd0);
    main_run(-1, -1, -1);
    chk("after_abort_cleared", {m_fv, m_ffv, m_ffm, m_err}, 0);
    chk("after_abort_pass", m_pass, 1);
    chk("after_abort_latency", r_lat, 17);

    // start together with abort in IDLE is ignored
    @(negedge clk); m_start = 1'b1; m_abort = 1'b1;
    @(negedge clk); m_start = 1'b0; m_abort = 1'b0;
    chk("start_abort_busy0", m_busy, 0);
    @(negedge clk);
    chk("start_abort_busy1", {m_busy, m_done}, 0);

    // Second start while busy is not queued
    main_run(-1, -1, 5);
    chk("restart_dones", r_dones, 1);
    chk("restart_latency", r_lat, 17);
    chk("restart_pass", m_pass, 1);

    // Abort in CHECK of vector 11 with a mismatch present: not counted
    set_faults(5'd0, 5'd0, 5'd0, 5'b10000);
    main_run(15, -1, -1);
    chk("abort_check_err", {tr_fv[16], tr_err[16]}, 0);
    chk("abort_check_dones", r_dones, 0);
    chk("abort_check_busy", tr_busy[16], 0);

    // Abort in DONE suppresses the done pulse
    set_faults(5'd0, 5'd0, 5'd0, 5'd0);
    main_run(16, -1, -1);
    chk("abort_done_dones", r_dones, 0);
    chk("abort_done_pass", m_pass, 0);

    // Reset during CHECK of vector 11
    set_faults(5'b00010, 5'd0, 5'd0, 5'd0);
    main_run(-1, 15, -1);
    chk("rst_mid_err_before", tr_err[15], 1);
    chk("rst_mid_outputs", {tr_busy[16], tr_done[16], tr_pass[16], tr_fv[16], tr_ff[16], tr_err[16], tr_gate[16]}, 0);
    chk("rst_mid_dones", r_dones, 0);
    set_faults(5'd0, 5'd0, 5'd0, 5'd0);

    // Multi-pass saturation: PASSES=100, ERR_W=3, and output inverted
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    n = 0;
    while (!s_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("sat_latency", n, 1601);
    chk("sat_err", s_err, 7);
    chk("sat_first", {s_fv, s_ffv, s_ffm}, {1'b1, 2'b00, 5'b00001});
    chk("sat_pass", s_pass, 0);

    // SETTLE_CYCLES=5: each vector held for 7 cycles
    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    r_lat = -1;
    for (int j = 0; j < 40; j++) begin
      tr_gate[j] = {w_ga, w_gb};
      if (w_done && r_lat < 0) r_lat = j;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      bad = 0;
      for (int j = 1 + 7 * k; j <= 7 + 7 * k; j++) if (tr_gate[j] != 2'(k)) bad++;
      chk($sformatf("slow_vec%0d_hold_bad", k), bad, 0);
    end
    chk("slow_latency", r_lat, 29);
    chk("slow_pass", {w_pass, w_err}, {1'b1, 8'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
